// File: rtl/branch_pkg.sv
// Shared types and helpers for the gshare branch predictor slice.
// FSM state enum, hash-mode encodings, counter init and saturation helpers.
package branch_pkg;

    typedef enum logic {
        INIT  = 1'b0,
        READY = 1'b1
    } fsm_state_e;

    localparam logic GLOBAL_MODE = 1'b0;
    localparam logic GSHARE_MODE = 1'b1;

    // Weakly-not-taken value; a 1-bit counter has no weak state, so it starts at 0.
    function automatic logic [3:0] wnt_value(input int ctr_w);
        if (ctr_w <= 1) begin
            return 4'd0;
        end
        return 4'((1 << (ctr_w - 1)) - 1);
    endfunction

    function automatic logic [3:0] sat_next(input logic [3:0] cur, input logic inc, input int ctr_w);
        logic [3:0] max_val;
        max_val = 4'((1 << ctr_w) - 1);
        if (inc) begin
            return (cur == max_val) ? cur : cur + 4'd1;
        end
        return (cur == 4'd0) ? cur : cur - 4'd1;
    endfunction

endpackage

// File: rtl/branch_gshare_pht.sv
// Pattern history table of saturating counters; write mux selects init sweep or update.
// Latency: combinational read, write lands at the next rising edge.
// Backpressure: none, every enabled write is taken in its cycle.
module branch_gshare_pht
    import branch_pkg::*;
#(
    parameter int PHT_IDX_W = 11,
    parameter int CTR_W     = 2
) (
    input  logic                 clk,
    input  logic [PHT_IDX_W-1:0] rd_idx,
    output logic [CTR_W-1:0]     rd_dat,
    input  logic                 init_en,
    input  logic [PHT_IDX_W-1:0] init_idx,
    input  logic                 upd_en,
    input  logic [PHT_IDX_W-1:0] upd_idx,
    input  logic                 upd_taken
);

    logic [CTR_W-1:0]     mem [2**PHT_IDX_W];
    logic                 wr_en;
    logic [PHT_IDX_W-1:0] wr_idx;
    logic [CTR_W-1:0]     wr_dat;

    always_comb begin
        wr_en  = init_en | upd_en;
        wr_idx = init_idx;
        wr_dat = CTR_W'(wnt_value(CTR_W));
        if (!init_en) begin
            wr_idx = upd_idx;
            wr_dat = CTR_W'(sat_next(4'(mem[upd_idx]), upd_taken, CTR_W));
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_idx] <= wr_dat;
        end
    end

    // Read returns the pre-write counter when read and write indices collide.
    assign rd_dat = mem[rd_idx];

endmodule

// File: rtl/branch_gshare_param.sv
// Parametrised global/gshare direction predictor with init sweep and GHR repair; BRANCH_GSHARE_STATS_EN adds counters.
// Latency: response registered one cycle after an accepted request.
// Backpressure: req_rdy low during the init sweep; responses and updates are never stalled.
module branch_gshare_param
    import branch_pkg::*;
#(
    parameter int PHT_IDX_W = 11,
    parameter int GHR_W     = 11,
    parameter int CTR_W     = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 hash_mode,
    input  logic                 req_val,
    output logic                 req_rdy,
    input  logic [31:0]          req_pc,
    output logic                 resp_val,
    output logic                 resp_taken,
    output logic [PHT_IDX_W-1:0] resp_idx,
    output logic [GHR_W-1:0]     resp_ghr,
    input  logic                 upd_val,
    input  logic [PHT_IDX_W-1:0] upd_idx,
    input  logic [GHR_W-1:0]     upd_ghr,
    input  logic                 upd_pred,
`ifdef BRANCH_GSHARE_STATS_EN
    input  logic                 upd_taken,
    output logic [31:0]          stat_preds,
    output logic [31:0]          stat_mispreds
`else
    input  logic                 upd_taken
`endif
);

    fsm_state_e           state_q, state_d;
    logic [PHT_IDX_W-1:0] ptr_q;
    logic [GHR_W-1:0]     ghr_q;
    logic [PHT_IDX_W-1:0] ghr_ext;
    logic [PHT_IDX_W-1:0] pc_slice;
    logic [PHT_IDX_W-1:0] idx;
    logic [CTR_W-1:0]     rd_dat;
    logic                 pred_bit;
    logic                 accept;
    logic                 upd_act;
    logic                 mispred;
    logic [GHR_W:0]       spec_ext;
    logic [GHR_W:0]       rep_ext;
    logic                 unused_bits;

    assign req_rdy  = (state_q == READY);
    assign accept   = req_val & req_rdy;
    assign upd_act  = upd_val & (state_q == READY);
    assign mispred  = upd_act & (upd_pred ^ upd_taken);
    assign pred_bit = rd_dat[CTR_W-1];
    assign pc_slice = req_pc[PHT_IDX_W+1:2];

    always_comb begin
        ghr_ext              = '0;
        ghr_ext[GHR_W-1:0]   = ghr_q;
        idx                  = (hash_mode == GSHARE_MODE) ? (pc_slice ^ ghr_ext) : ghr_ext;
    end

    // Shifting through a GHR_W+1 wide concat keeps GHR_W=1 legal without a special case.
    assign spec_ext    = {ghr_q, pred_bit};
    assign rep_ext     = {upd_ghr, upd_taken};
    assign unused_bits = ^{req_pc, spec_ext[GHR_W], rep_ext[GHR_W], rd_dat};

    always_comb begin
        state_d = state_q;
        case (state_q)
            INIT:    if (ptr_q == '1) state_d = READY;
            READY:   state_d = READY;
            default: state_d = INIT;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= INIT;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == INIT) begin
                ptr_q <= ptr_q + PHT_IDX_W'(1);
            end
        end
    end

    // A resolved mispredict rewrites history and outranks any same-cycle speculative shift.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ghr_q <= '0;
        end else if (mispred) begin
            ghr_q <= rep_ext[GHR_W-1:0];
        end else if (accept) begin
            ghr_q <= spec_ext[GHR_W-1:0];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            resp_val   <= 1'b0;
            resp_taken <= 1'b0;
            resp_idx   <= '0;
            resp_ghr   <= '0;
        end else begin
            resp_val <= accept;
            if (accept) begin
                resp_taken <= pred_bit;
                resp_idx   <= idx;
                resp_ghr   <= ghr_q;
            end
        end
    end

`ifdef BRANCH_GSHARE_STATS_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stat_preds    <= '0;
            stat_mispreds <= '0;
        end else begin
            if (accept)  stat_preds    <= stat_preds + 32'd1;
            if (mispred) stat_mispreds <= stat_mispreds + 32'd1;
        end
    end
`endif

    branch_gshare_pht #(
        .PHT_IDX_W (PHT_IDX_W),
        .CTR_W     (CTR_W)
    ) u_pht (
        .clk       (clk),
        .rd_idx    (idx),
        .rd_dat    (rd_dat),
        .init_en   (state_q == INIT),
        .init_idx  (ptr_q),
        .upd_en    (upd_act),
        .upd_idx   (upd_idx),
        .upd_taken (upd_taken)
    );

endmodule

// File: tb/tb_branch_gshare_param.sv
// Directed bench for branch_gshare_param at default parameters; BRANCH_GSHARE_STATS_EN also checks the counters.
module tb_branch_gshare_param;

    logic        clk = 1'b0;
    logic        reset;
    logic        hash_mode;
    logic        req_val;
    logic        req_rdy;
    logic [31:0] req_pc;
    logic        resp_val;
    logic        resp_taken;
    logic [10:0] resp_idx;
    logic [10:0] resp_ghr;
    logic        upd_val;
    logic [10:0] upd_idx;
    logic [10:0] upd_ghr;
    logic        upd_pred;
    logic        upd_taken;
`ifdef BRANCH_GSHARE_STATS_EN
    logic [31:0] stat_preds;
    logic [31:0] stat_mispreds;
`endif

    int tests = 0;
    int fails = 0;
    int exp_preds = 0;
    int exp_mis = 0;

    always #5 clk = ~clk;

    branch_gshare_param dut (
        .clk        (clk),
        .reset      (reset),
        .hash_mode  (hash_mode),
        .req_val    (req_val),
        .req_rdy    (req_rdy),
        .req_pc     (req_pc),
        .resp_val   (resp_val),
        .resp_taken (resp_taken),
        .resp_idx   (resp_idx),
        .resp_ghr   (resp_ghr),
        .upd_val    (upd_val),
        .upd_idx    (upd_idx),
        .upd_ghr    (upd_ghr),
        .upd_pred   (upd_pred),
`ifdef BRANCH_GSHARE_STATS_EN
        .upd_taken  (upd_taken),
        .stat_preds (stat_preds),
        .stat_mispreds (stat_mispreds)
`else
        .upd_taken  (upd_taken)
`endif
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_ready(input string tag);
        int cnt;
        cnt = 0;
        while (req_rdy !== 1'b1 && cnt < 5000) begin
            tick();
            cnt++;
        end
        chk(tag, 32'(cnt), 32'd2048);
    endtask

    task automatic do_pred(input string tag, input logic mode, input logic [31:0] pc,
                           input logic [31:0] e_idx, input logic [31:0] e_ghr, input logic e_taken);
        req_val   = 1'b1;
        hash_mode = mode;
        req_pc    = pc;
        tick();
        req_val   = 1'b0;
        exp_preds++;
        chk({tag, "_val"},   32'(resp_val),   32'd1);
        chk({tag, "_idx"},   32'(resp_idx),   e_idx);
        chk({tag, "_ghr"},   32'(resp_ghr),   e_ghr);
        chk({tag, "_taken"}, 32'(resp_taken), 32'(e_taken));
    endtask

    task automatic do_upd(input logic [10:0] idx, input logic [10:0] ghr, input logic pred, input logic tkn);
        upd_val   = 1'b1;
        upd_idx   = idx;
        upd_ghr   = ghr;
        upd_pred  = pred;
        upd_taken = tkn;
        tick();
        upd_val   = 1'b0;
        if (pred != tkn) exp_mis++;
    endtask

    task automatic chk_stats(input string tag);
`ifdef BRANCH_GSHARE_STATS_EN
        chk({tag, "_preds"},   stat_preds,    32'(exp_preds));
        chk({tag, "_mispreds"}, stat_mispreds, 32'(exp_mis));
`else
        tests = tests + 0;
`endif
    endtask

    initial begin
        reset = 1'b0; hash_mode = 1'b0; req_val = 1'b0; req_pc = '0;
        upd_val = 1'b0; upd_idx = '0; upd_ghr = '0; upd_pred = 1'b0; upd_taken = 1'b0;

        // Reset values and full-length init sweep
        repeat (3) tick();
        chk("rst_rdy",   32'(req_rdy),    32'd0);
        chk("rst_val",   32'(resp_val),   32'd0);
        chk("rst_taken", 32'(resp_taken), 32'd0);
        chk("rst_idx",   32'(resp_idx),   32'd0);
        chk("rst_ghr",   32'(resp_ghr),   32'd0);
        chk_stats("rst_stats");
        reset = 1'b1;
        wait_ready("init_len");
        do_pred("first", 1'b0, 32'h1234_5678, 32'h000, 32'h000, 1'b0);
        tick();
        chk("val_drop", 32'(resp_val), 32'd0);

        // Counter climbs 1->2->3 and saturates on the third taken update
        do_upd(11'h000, 11'h000, 1'b1, 1'b1);
        do_upd(11'h000, 11'h000, 1'b1, 1'b1);
        do_upd(11'h000, 11'h000, 1'b1, 1'b1);
        do_pred("sat", 1'b0, 32'h0, 32'h000, 32'h000, 1'b1);

        // Repair GHR to 0x005, then gshare with PC 0x40
        do_upd(11'h700, 11'h002, 1'b0, 1'b1);
        do_pred("gshare", 1'b1, 32'h0000_0040, 32'h015, 32'h005, 1'b0);
        do_pred("ghr_shift", 1'b0, 32'h0, 32'h00A, 32'h00A, 1'b0);

        // Back-to-back, then a colliding request alongside a mispredict repair
        do_pred("b2b0", 1'b0, 32'h0, 32'h014, 32'h014, 1'b0);
        do_pred("b2b1", 1'b0, 32'h0, 32'h028, 32'h028, 1'b0);
        do_pred("b2b2", 1'b0, 32'h0, 32'h050, 32'h050, 1'b0);
        upd_val = 1'b1; upd_idx = 11'h0A0; upd_ghr = 11'h003; upd_pred = 1'b0; upd_taken = 1'b1;
        exp_mis++;
        do_pred("collide", 1'b0, 32'h0, 32'h0A0, 32'h0A0, 1'b0);
        upd_val = 1'b0;
        do_pred("repaired", 1'b0, 32'h0, 32'h007, 32'h007, 1'b0);
        do_pred("coll_wr", 1'b1, 32'h0000_02B8, 32'h0A0, 32'h00E, 1'b1);
        chk_stats("run_stats");

        // Mid-sweep reset restarts; updates during INIT must not touch GHR or PHT
        reset = 1'b0;
        tick();
        exp_preds = 0; exp_mis = 0;
        reset = 1'b1;
        upd_val = 1'b1; upd_idx = 11'h0A0; upd_ghr = 11'h3FF; upd_pred = 1'b0; upd_taken = 1'b1;
        repeat (500) tick();
        chk("mid_rdy", 32'(req_rdy), 32'd0);
        reset = 1'b0;
        tick();
        chk("mid_rst_rdy", 32'(req_rdy), 32'd0);
        reset = 1'b1;
        wait_ready("restart_len");
        upd_val = 1'b0;
        chk_stats("frozen_stats");
        for (int i = 0; i < 2048; i++) begin
            do_pred("wnt", 1'b1, 32'(i) << 2, 32'(i), 32'h000, 1'b0);
        end

        // Four mispredicting updates on top of the sweep's predictions
        for (int i = 0; i < 4; i++) begin
            do_upd(11'(i + 16), 11'h000, 1'b1, 1'b0);
        end
        do_upd(11'h020, 11'h000, 1'b1, 1'b1);
        chk_stats("final_stats");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/branch_gshare_param.md
Name: branch_gshare_param

Overview:
Parametrised successor to the fixed-size global predictor: a PHT of CTR_W-bit saturating counters indexed by global history, either alone or XORed with PC (gshare).
- Adds a reset-time PHT initialisation sweep, a valid/ready request port and a one-cycle registered response.
- Adds speculative GHR update with misprediction repair from a checkpoint returned with each prediction.
- Sits between fetch (request/response) and the branch-resolve stage (update).

Parameters:
PHT_IDX_W, 11, log2 of PHT entries (2048 default).
GHR_W, 11, global history length in bits; must satisfy 1 <= GHR_W <= PHT_IDX_W.
CTR_W, 2, saturating counter width in bits; must satisfy 1 <= CTR_W <= 4.

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low reset (0 = in reset)
hash_mode  in  1  0 = global index (GHR only), 1 = gshare (PC xor GHR); sampled on request accept
req_val  in  1  prediction request valid
req_rdy  out  1  predictor can accept a request
req_pc  in  32  branch PC
resp_val  out  1  response valid, exactly one cycle after an accepted request
resp_taken  out  1  predicted direction
resp_idx  out  PHT_IDX_W  PHT index used; fetch carries it to resolve
resp_ghr  out  GHR_W  GHR value before this prediction's speculative shift (checkpoint)
upd_val  in  1  resolved-branch update valid; always accepted
upd_idx  in  PHT_IDX_W  index from resp_idx
upd_ghr  in  GHR_W  checkpoint from resp_ghr
upd_pred  in  1  direction originally predicted
upd_taken  in  1  actual direction

Behaviour:
- Reset is asserted asynchronously. Outputs during and after reset: req_rdy=0, resp_val=0, resp_taken=0, resp_idx=0, resp_ghr=0. GHR=0, FSM=INIT, init pointer=0.
- FSM INIT:
  - Each cycle writes WNT = 2^(CTR_W-1)-1 to PHT[ptr] (CTR_W=1 -> 0), then ptr++.
  - After writing entry 2^PHT_IDX_W-1, the next state is READY.
  - Total INIT time is 2^PHT_IDX_W cycles; req_rdy=0 and upd_val is ignored throughout.
- FSM READY: req_rdy=1. READY is left only by reset.
- Reset asserted mid-sweep or in READY returns the FSM to INIT with ptr=0 and restarts the full sweep.
- Index computation:
  - g = GHR zero-extended to PHT_IDX_W.
  - Global mode: idx = g.
  - Gshare mode: idx = req_pc[PHT_IDX_W+1:2] ^ g.
- Request accept (req_val & req_rdy), registered into the next cycle:
  - resp_val=1.
  - resp_idx=idx.
  - resp_taken = MSB of PHT[idx] as read in the accept cycle.
  - resp_ghr = GHR used for idx.
- On accept, GHR <= {GHR[GHR_W-2:0], predicted bit} (for GHR_W=1, GHR <= predicted bit).
- resp_val deasserts in any cycle following no accept. There is no response backpressure.
- Update (upd_val in READY):
  - PHT[upd_idx] counter increments if upd_taken, decrements otherwise, saturating at 0 and 2^CTR_W-1.
  - Mispredict (upd_pred != upd_taken): GHR <= {upd_ghr[GHR_W-2:0], upd_taken}. This overrides the speculative shift from any request accepted the same cycle.
- Simultaneous request and update in the same cycle:
  - The request index is computed from the pre-update GHR.
  - The PHT read sees the pre-update counter, including when the indices collide.
  - A mispredict repair wins the GHR write.
- No width mismatch is allowed: the PC slice and GHR are explicitly sized to PHT_IDX_W.

Optional Feature:
Macro BRANCH_GSHARE_STATS_EN.
- Defined: adds output ports stat_preds (32 bits) and stat_mispreds (32 bits), both reset to 0.
  - stat_preds increments on each accepted request.
  - stat_mispreds increments on each upd_val with upd_pred != upd_taken.
  - Both wrap at 2^32 and are frozen during INIT.
- Undefined: the ports and counters are absent and there is no behavioural change otherwise.

Decomposition:
- Shared package branch_pkg holds:
  - the FSM state enum (INIT, READY);
  - hash_mode encodings GLOBAL_MODE=0 and GSHARE_MODE=1;
  - a function computing the WNT initial value from CTR_W;
  - a saturating-counter next-value function.
- One sub-module, branch_gshare_pht: the counter array with one read port, one write port, and a write mux between init-sweep data and update data.
- The FSM, GHR and response registers live in the top module.

Test Plan:
1. Reset low 3 cycles, then high (defaults) -> req_rdy=0 for exactly 2048 cycles, then 1; first prediction on any PC returns resp_taken=0.
2. Global mode, CTR_W=2: 2 accepted updates taken to idx 0 -> counter 1->3; a third taken update saturates at 3; a prediction with GHR=0 -> resp_taken=1, resp_idx=0.
3. Gshare, GHR=0x005, req_pc=0x0000_0040 -> resp_idx=0x010^0x005=0x015 one cycle later; resp_ghr=0x005; GHR becomes 0x00A or 0x00B per the prediction.
4. Three back-to-back predictions, then a mispredict update with upd_ghr=0x003, upd_taken=1 in the same cycle as a fourth request -> GHR=0x007 next cycle; the fourth request's resp_ghr shows the pre-repair GHR.
5. Reset pulsed low at cycle 500 of the INIT sweep -> sweep restarts; req_rdy rises 2048 cycles after deassertion; all entries read WNT.
6. With BRANCH_GSHARE_STATS_EN: 10 predictions and 4 mispredicting updates -> stat_preds=10, stat_mispreds=4; both are 0 after reset.
